// File: rtl/fifo_read_drain.sv
// Read-side FIFO consumer: pops first-word-fall-through data into a 2-entry
// skid buffer that feeds a registered valid/ready stream, with flush and counters.
module fifo_read_drain #(
    parameter int WORDSIZE = 8,
    parameter int CNTW     = 16
) (
    input  logic                rclk,
    input  logic                rst,
    input  logic                empty,
    input  logic [WORDSIZE-1:0] read_data,
    output logic                signal_read,
    input  logic                enable,
    input  logic                flush,
    output logic [WORDSIZE-1:0] out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CNTW-1:0]     rd_count,
    output logic [CNTW-1:0]     drop_count
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t              state;
    logic                vld_p1;
    logic [WORDSIZE-1:0] head_data_p1;
    logic [WORDSIZE-1:0] skid_data_p1;
    logic                push;
    logic                pop;

    // Words lost to a flush: whatever was buffered minus a word that left this cycle.
    function automatic logic [CNTW-1:0] drop_amount(input state_t s, input logic p);
        logic [CNTW-1:0] amt;
        amt = '0;
        unique case (s)
            ST_ONE:  amt = p ? CNTW'(0) : CNTW'(1);
            ST_TWO:  amt = p ? CNTW'(1) : CNTW'(2);
            default: amt = '0;
        endcase
        return amt;
    endfunction

    // Pop decision ignores out_ready so the stream never loops back into the FIFO.
    assign signal_read = !rst && enable && !empty && !flush && (state != ST_TWO);
    assign push        = signal_read;
    assign pop         = vld_p1 && out_ready;
    assign out_valid   = vld_p1;
    assign out_data    = head_data_p1;

    // Stage p1: occupancy, head word and counters.
    always_ff @(posedge rclk) begin
        if (rst) begin
            state        <= ST_EMPTY;
            vld_p1       <= 1'b0;
            head_data_p1 <= '0;
            rd_count     <= '0;
            drop_count   <= '0;
        end else begin
            if (push) begin
                rd_count <= rd_count + CNTW'(1);
            end
            if (flush) begin
                state      <= ST_EMPTY;
                vld_p1     <= 1'b0;
                drop_count <= drop_count + drop_amount(state, pop);
            end else begin
                unique case (state)
                    ST_EMPTY: begin
                        if (push) begin
                            head_data_p1 <= read_data;
                            state        <= ST_ONE;
                            vld_p1       <= 1'b1;
                        end
                    end
                    ST_ONE: begin
                        if (push && pop) begin
                            head_data_p1 <= read_data;
                        end else if (push) begin
                            state <= ST_TWO;
                        end else if (pop) begin
                            state  <= ST_EMPTY;
                            vld_p1 <= 1'b0;
                        end
                    end
                    ST_TWO: begin
                        if (pop) begin
                            head_data_p1 <= skid_data_p1;
                            state        <= ST_ONE;
                        end
                    end
                    default: begin
                        state  <= ST_EMPTY;
                        vld_p1 <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Skid register only matters in TWO, so it carries no reset.
    always_ff @(posedge rclk) begin
        if (state == ST_ONE && push && !pop) begin
            skid_data_p1 <= read_data;
        end
    end

endmodule

// File: tb/tb_fifo_read_drain.sv
// Bench for fifo_read_drain: queue-based model of the FIFO and the 2-word buffer,
// directed scenarios followed by randomized traffic.
module tb_fifo_read_drain;

    logic        rclk;
    logic        rst;
    logic        empty;
    logic [7:0]  read_data;
    logic        signal_read;
    logic        enable;
    logic        flush;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] rd_count;
    logic [15:0] drop_count;

    logic        signal_read_w4;
    logic [7:0]  out_data_w4;
    logic        out_valid_w4;
    logic [3:0]  rd_count_w4;
    logic [3:0]  drop_count_w4;

    fifo_read_drain #(.WORDSIZE(8), .CNTW(16)) dut (
        .rclk(rclk), .rst(rst), .empty(empty), .read_data(read_data),
        .signal_read(signal_read), .enable(enable), .flush(flush),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .rd_count(rd_count), .drop_count(drop_count)
    );

    fifo_read_drain #(.WORDSIZE(8), .CNTW(4)) dut_w4 (
        .rclk(rclk), .rst(rst), .empty(empty), .read_data(read_data),
        .signal_read(signal_read_w4), .enable(enable), .flush(flush),
        .out_data(out_data_w4), .out_valid(out_valid_w4), .out_ready(out_ready),
        .rd_count(rd_count_w4), .drop_count(drop_count_w4)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    int checks = 0;
    int errors = 0;

    // Reference model: FIFO contents, buffered words in delivery order, counters.
    logic [7:0] fq[$];
    logic [7:0] bq[$];
    logic [7:0] last_head;
    int         rd_m;
    int         drop_m;
    logic       last_sr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycle(input logic r, input logic en, input logic fl, input logic rdy);
        logic       exp_sr;
        logic       pop_m;
        logic [7:0] exp_data;
        @(negedge rclk);
        rst       = r;
        enable    = en;
        flush     = fl;
        out_ready = rdy;
        empty     = (fq.size() == 0);
        read_data = empty ? 8'($urandom) : fq[0];
        #1;
        exp_sr   = !r && en && (fq.size() != 0) && !fl && (bq.size() < 2);
        exp_data = (bq.size() != 0) ? bq[0] : last_head;
        check("signal_read", {31'd0, signal_read}, {31'd0, exp_sr});
        check("out_valid", {31'd0, out_valid}, {31'd0, bq.size() != 0});
        check("out_data", {24'd0, out_data}, {24'd0, exp_data});
        check("rd_count", {16'd0, rd_count}, 32'(rd_m % 65536));
        check("drop_count", {16'd0, drop_count}, 32'(drop_m % 65536));
        check("rd_count_w4", {28'd0, rd_count_w4}, 32'(rd_m % 16));
        check("drop_count_w4", {28'd0, drop_count_w4}, 32'(drop_m % 16));
        check("out_data_w4", {24'd0, out_data_w4}, {24'd0, exp_data});
        last_sr = signal_read;
        pop_m   = (bq.size() != 0) && rdy;
        if (r) begin
            bq.delete();
            last_head = 8'h00;
            rd_m      = 0;
            drop_m    = 0;
        end else begin
            if (fl) begin
                drop_m += bq.size() - int'(pop_m);
                bq.delete();
            end else begin
                if (pop_m) void'(bq.pop_front());
                if (exp_sr) bq.push_back(fq[0]);
            end
            if (exp_sr) begin
                rd_m++;
                void'(fq.pop_front());
            end
            if (bq.size() != 0) last_head = bq[0];
        end
    endtask

    task automatic add_words(input int n);
        for (int i = 0; i < n; i++) fq.push_back(8'($urandom));
    endtask

    int sr_pulses;

    initial begin
        rst = 1'b1; enable = 1'b0; flush = 1'b0; out_ready = 1'b0;
        empty = 1'b1; read_data = 8'h00;
        last_head = 8'h00; rd_m = 0; drop_m = 0; last_sr = 1'b0;
        repeat (2) @(posedge rclk);

        // Reset state, including signal_read held low while rst is high.
        fq.push_back(8'h11);
        cycle(1'b1, 1'b1, 1'b0, 1'b1);
        fq.delete();
        fq.push_back(8'h11); fq.push_back(8'h22); fq.push_back(8'h33);
        repeat (5) cycle(1'b0, 1'b1, 1'b0, 1'b1);
        @(posedge rclk); #1;
        check("preload_rd_count", {16'd0, rd_count}, 32'd3);
        check("preload_drop_count", {16'd0, drop_count}, 32'd0);

        // Backpressure: exactly two pops, then held in TWO with word0 at head.
        add_words(5);
        sr_pulses = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b0);
            sr_pulses += int'(last_sr);
        end
        check("bp_pulses", 32'(sr_pulses), 32'd2);
        repeat (8) cycle(1'b0, 1'b1, 1'b0, 1'b1);
        @(posedge rclk); #1;
        check("bp_rd_count", {16'd0, rd_count}, 32'd8);

        // Flush from TWO with no pop drops two words; popping resumes next cycle.
        add_words(4);
        repeat (3) cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check("flush_resume_sr", {31'd0, last_sr}, 32'd1);
        check("flush_drop", {16'd0, drop_count}, 32'd2);

        // Flush in ONE together with a pop: delivered, nothing dropped.
        repeat (4) cycle(1'b0, 1'b1, 1'b0, 1'b1);
        add_words(1);
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 1'b1);

        // enable low stops popping while the buffered word drains.
        add_words(4);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (4) cycle(1'b0, 1'b1, 1'b0, 1'b1);

        // Reset while in TWO clears everything without counting drops.
        add_words(4);
        repeat (3) cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        fq.delete();

        // Randomized traffic; rd_count wraps the 4-bit instance many times.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(1, 0) == 1 && fq.size() < 8) add_words(int'($urandom_range(3, 1)));
            cycle(($urandom_range(59, 0) == 0),
                  ($urandom_range(3, 0) != 0),
                  ($urandom_range(15, 0) == 0),
                  ($urandom_range(1, 0) == 1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_read_drain.md
# fifo_read_drain

Read-side consumer for the asynchronous FIFO, clocked in the read clock domain. It watches `empty`, captures first-word-fall-through `read_data`, and pulses `signal_read` to pop the FIFO. Words are delivered on a registered valid/ready stream through a 2-entry skid buffer. Also provides flush control and word/drop counters for the read side.

## Interface

Parameters:
- `WORDSIZE`, 8, data word width; matches the FIFO word width.
- `CNTW`, 16, width of the `rd_count` and `drop_count` counters.

Ports:
- `rclk`  input  1  read-domain clock; all state updates on the rising edge.
- `rst`  input  1  reset; synchronous and active-high.
- `empty`  input  1  FIFO empty flag, already in the `rclk` domain.
- `read_data`  input  WORDSIZE  FIFO head word; valid combinationally whenever `empty`=0.
- `signal_read`  output  1  FIFO pop; one word is consumed per `rclk` edge while high.
- `enable`  input  1  permits popping; when 0, buffered words still drain.
- `flush`  input  1  single-cycle synchronous discard of buffered words.
- `out_data`  output  WORDSIZE  stream data (registered).
- `out_valid`  output  1  stream valid (registered).
- `out_ready`  input  1  stream ready from the downstream block.
- `rd_count`  output  CNTW  words popped from the FIFO; wraps modulo 2^CNTW.
- `drop_count`  output  CNTW  words discarded by flush; wraps modulo 2^CNTW.

## Operation

- The buffer holds a head register (drives `out_data`) and one skid register. Occupancy state is one of EMPTY(0), ONE(1) or TWO(2).
- `out_valid` = (state != EMPTY).
- Definitions:
  - push = `signal_read`.
  - pop = `out_valid` & `out_ready`.
- `signal_read` = !`rst` & `enable` & !`empty` & !`flush` & (state != TWO).
  - Combinational.
  - No path from `out_ready`.
- Transitions (no flush):
  - EMPTY: push → head←`read_data`, ONE.
  - ONE:
    - push&pop → head←`read_data`, stay ONE.
    - push only → skid←`read_data`, TWO.
    - pop only → EMPTY.
    - neither → hold.
  - TWO:
    - pop → head←skid, ONE.
    - else hold. Push is impossible in TWO.
- Flush (highest priority below `rst`):
  - Next state is EMPTY.
  - `signal_read` is 0 in the flush cycle.
  - A pop in the flush cycle counts as delivered.
  - `drop_count` += occupancy − pop (0, 1 or 2).
- `rd_count` += 1 on every edge with `signal_read`=1.
- `out_data` holds its last value when EMPTY; it is not cleared except by `rst`.
- Ordering: words leave in exactly the FIFO pop order, with no duplication and no loss except by flush.
- Skid register contents are don't-care outside TWO.

## Timing

- Reset values (edge with `rst`=1):
  - state EMPTY, `out_valid`=0, `out_data`=0.
  - `rd_count`=0, `drop_count`=0.
  - `signal_read`=0 throughout the reset cycle.
- Reset mid-operation discards buffered words without incrementing `drop_count`.
- Latency: a word at the FIFO head with `empty`=0 at cycle t, state≠TWO and `enable`=1:
  - `signal_read` is high in t.
  - The word appears on `out_data` with `out_valid`=1 at t+1.
- Throughput: 1 word/cycle sustained when `out_ready`=1 and `empty`=0 (state stays ONE).
- Backpressure: after `out_ready` drops, at most one further word is popped. The state reaches TWO and `signal_read` then stays 0.
- Stream rule: once `out_valid`=1, `out_valid` and `out_data` stay stable until pop or flush.
- `enable` low: `signal_read` is 0 in the same cycle. The buffer keeps draining to downstream.
- `empty` rising while in ONE with `out_ready`=1: the pop drains the buffer, leaving EMPTY the next cycle.

## Test plan

- Reset, then FIFO preloaded with 0x11,0x22,0x33, `out_ready`=1 → first `out_valid` one cycle after the first `signal_read`. Data 0x11,0x22,0x33 arrive on consecutive cycles; `rd_count`=3, `drop_count`=0.
- `out_ready`=0 with 5 words in the FIFO → exactly 2 `signal_read` pulses, then state TWO, `out_data`=word0. Raise `out_ready` → word0..word4 delivered in order, `rd_count`=5.
- In TWO, pulse `flush` with `out_ready`=0 → `out_valid`=0 next cycle, `drop_count`=2, no `signal_read` during the flush cycle. Popping resumes the following cycle if `empty`=0.
- In ONE, `flush` with `out_ready`=1 in the same cycle → word counted as delivered, `drop_count` unchanged, state EMPTY.
- `enable`=0 with buffer ONE and `empty`=0 → `signal_read` stays 0 and the buffered word drains. `enable`=1 → popping restarts the same cycle.
- `CNTW`=4, pop 17 words → `rd_count`=1 (wrap). Assert `rst` mid-stream in TWO → all outputs at reset values one edge later, `drop_count`=0.
